spi_rom_fetch: RTL and testbench

SPI_ROM_FETCH -- requirements
Module: spi_rom_fetch

---
 rtl/jrb8_pkg.sv | 34 +++
 rtl/spi_shifter.sv | 103 ++++++++++
 rtl/spi_rom_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_spi_rom_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jrb8_pkg.sv
// -----------------------------------------------------------------------------
// jrb8_pkg
// Shared definitions for the SPI serial-ROM fetch block:
//   - fetch controller state encoding
//   - default serial-memory read opcode
//   - chip-select gap length between non-sequential transfers
//   - counter widths used by the bit shifter
// -----------------------------------------------------------------------------
package jrb8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSGAP,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_HOLD
    } state_t;

    localparam logic [7:0]  READ_CMD_DEFAULT = 8'h03;
    localparam int unsigned CSGAP_CYCLES     = 2;

    // SCK half-period divider (CLK_DIV up to 15), bit counter (up to 16 bits),
    // transmit shift register (widest field is the 16-bit address).
    localparam int unsigned DIV_W   = 4;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned SHIFT_W = 16;

    // States in which the shifter drives SCK.
    function automatic logic is_shift_state(input state_t s);
        return s inside {ST_CMD, ST_ADDR, ST_DATA};
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// -----------------------------------------------------------------------------
// spi_shifter
// SPI mode-0 bit engine. Generates SCK from the system clock, shifts a
// left-justified word out on MOSI and collects MISO into an 8-bit register.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   i_load       start a new field: clears counters, loads i_tx_data/i_nbits
//   i_run        advance the bit timing this cycle (ignored while i_load)
//   i_tx_data    field to send, MSB first, left-justified in SHIFT_W bits
//   i_nbits      number of bits in the field
//   i_miso       serial data from the memory
//   o_sck        serial clock
//   o_mosi       serial data to the memory
//   o_rx         last 8 bits sampled from MISO, MSB first
//   o_done       high during the final cycle of the last bit's high phase
//
// With neither i_load nor i_run every counter and SCK/MOSI return to zero.
// -----------------------------------------------------------------------------
module spi_shifter
    import jrb8_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_run,
    input  logic [SHIFT_W-1:0] i_tx_data,
    input  logic [BIT_W-1:0]   i_nbits,
    input  logic               i_miso,
    output logic               o_sck,
    output logic               o_mosi,
    output logic [7:0]         o_rx,
    output logic               o_done
);

    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic [BIT_W-1:0]   r_nbits;
    logic [SHIFT_W-1:0] r_tx;
    logic [7:0]         r_rx;
    logic               r_sck;
    logic               r_mosi;

    logic               w_phase_end;
    logic               w_last_bit;

    assign w_phase_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit == (r_nbits - BIT_W'(1)));

    // SCK is low outside a shifting field, so done can only fire inside one.
    assign o_done = r_sck & w_phase_end & w_last_bit;
    assign o_sck  = r_sck;
    assign o_mosi = r_mosi;
    assign o_rx   = r_rx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_nbits <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else if (i_load) begin
            // First bit goes onto MOSI at the start of its low phase.
            r_div   <= '0;
            r_bit   <= '0;
            r_nbits <= i_nbits;
            r_tx    <= i_tx_data;
            r_rx    <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= i_tx_data[SHIFT_W-1];
        end else if (i_run) begin
            if (!w_phase_end) begin
                r_div <= r_div + DIV_W'(1);
            end else begin
                r_div <= '0;
                if (!r_sck) begin
                    // Rising SCK: memory data is sampled on this same edge.
                    r_sck <= 1'b1;
                    r_rx  <= {r_rx[6:0], i_miso};
                end else begin
                    // Falling SCK: next bit presented for the new low phase.
                    r_sck  <= 1'b0;
                    r_bit  <= r_bit + BIT_W'(1);
                    r_tx   <= {r_tx[SHIFT_W-2:0], 1'b0};
                    r_mosi <= r_tx[SHIFT_W-2];
                end
            end
        end else begin
            r_div   <= '0;
            r_bit   <= '0;
            r_nbits <= '0;
            r_tx    <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_rom_fetch.sv
// -----------------------------------------------------------------------------
// spi_rom_fetch
// Fetches single bytes from an SPI serial memory (mode 0). A request from
// IDLE sends READ_CMD, the 16-bit address and reads one byte. Chip select is
// then held low in HOLD so a request for the next address streams the
// following byte with no command/address phase. Any other address goes
// through a short CS-high gap and a full read. HOLD releases CS after
// HOLD_TIMEOUT idle cycles.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   req, addr    fetch request and byte address, sampled while busy=0
//   rdata        fetched byte, held until the next valid pulse
//   valid        one-cycle pulse when rdata updates
//   busy         high from the cycle after acceptance through the valid cycle
//   spi_cs_n     memory chip select, active-low
//   spi_sck      serial clock
//   spi_mosi     serial data to the memory
//   spi_miso     serial data from the memory
// -----------------------------------------------------------------------------
module spi_rom_fetch
    import jrb8_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned HOLD_TIMEOUT = 64,
    parameter logic [7:0]  READ_CMD     = READ_CMD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr,
    output logic [7:0]  rdata,
    output logic        valid,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned TO_W  = $clog2(HOLD_TIMEOUT + 1);
    localparam int unsigned GAP_W = (CSGAP_CYCLES > 1) ? $clog2(CSGAP_CYCLES) : 1;

    state_t             r_state;
    logic [15:0]        r_addr;      // latched address, doubles as last_addr in HOLD
    logic [7:0]         r_rdata;
    logic               r_valid;
    logic [TO_W-1:0]    r_to;
    logic [GAP_W-1:0]   r_gap;

    state_t             w_state_nxt;
    logic [15:0]        w_addr_nxt;
    logic [7:0]         w_rdata_nxt;
    logic               w_valid_nxt;
    logic [TO_W-1:0]    w_to_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;

    logic               w_seq;
    logic               w_load;
    logic               w_run;
    logic [SHIFT_W-1:0] w_tx_data;
    logic [BIT_W-1:0]   w_nbits;
    logic [7:0]         w_rx;
    logic               w_done;

    // 17-bit compare so that last_addr=16'hFFFF never matches addr=16'h0000.
    assign w_seq = ({1'b0, addr} == ({1'b0, r_addr} + 17'd1));

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_rdata_nxt = r_rdata;
        w_valid_nxt = 1'b0;
        w_to_nxt    = r_to;
        w_gap_nxt   = r_gap;
        w_load      = 1'b0;
        w_tx_data   = '0;
        w_nbits     = '0;

        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_addr_nxt  = addr;
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CSGAP: begin
                if (r_gap == GAP_W'(CSGAP_CYCLES - 1)) begin
                    w_state_nxt = ST_CMD;
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end
            ST_CMD: begin
                if (w_done) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_done) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_done) begin
                    w_rdata_nxt = w_rx;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The valid cycle sits in HOLD but is still busy: requests
                // are ignored and the timeout does not run yet.
                if (r_valid) begin
                    w_to_nxt = '0;
                end else if (req) begin
                    w_addr_nxt  = addr;
                    w_to_nxt    = '0;
                    w_state_nxt = w_seq ? ST_DATA : ST_CSGAP;
                end else if (r_to == TO_W'(HOLD_TIMEOUT - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_to_nxt = r_to + TO_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Every state entry starts with fresh counters; entering a shifting
        // state also loads the shifter with that state's field.
        if (w_state_nxt != r_state) begin
            w_to_nxt  = '0;
            w_gap_nxt = '0;
            case (w_state_nxt)
                ST_CMD: begin
                    w_load    = 1'b1;
                    w_tx_data = {READ_CMD, 8'h00};
                    w_nbits   = BIT_W'(8);
                end
                ST_ADDR: begin
                    w_load    = 1'b1;
                    w_tx_data = r_addr;
                    w_nbits   = BIT_W'(16);
                end
                ST_DATA: begin
                    w_load    = 1'b1;
                    w_tx_data = '0;
                    w_nbits   = BIT_W'(8);
                end
                default: begin
                    w_load = 1'b0;
                end
            endcase
        end
    end

    assign w_run = is_shift_state(w_state_nxt) & ~w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_to    <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_rdata <= w_rdata_nxt;
            r_valid <= w_valid_nxt;
            r_to    <= w_to_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_run     (w_run),
        .i_tx_data (w_tx_data),
        .i_nbits   (w_nbits),
        .i_miso    (spi_miso),
        .o_sck     (spi_sck),
        .o_mosi    (spi_mosi),
        .o_rx      (w_rx),
        .o_done    (w_done)
    );

    // Decoded from the state register so reset releases CS immediately.
    assign spi_cs_n = (r_state == ST_IDLE) | (r_state == ST_CSGAP);
    assign busy     = (r_state == ST_CSGAP) | is_shift_state(r_state) | r_valid;
    assign valid    = r_valid;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_spi_rom_fetch.sv
// -----------------------------------------------------------------------------
// tb_spi_rom_fetch
// Self-checking bench for spi_rom_fetch with a behavioural SPI serial memory
// (byte i = i[7:0] ^ 8'h5A, sequential read continues through the array).
// -----------------------------------------------------------------------------
module tb_spi_rom_fetch;

    localparam int unsigned CD = 2;
    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic [7:0]  rdata;
    logic        valid;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model of the controller's stream state
    bit          m_hold = 1'b0;
    logic [15:0] m_last = 16'h0000;

    spi_rom_fetch #(
        .CLK_DIV      (CD),
        .HOLD_TIMEOUT (TO),
        .READ_CMD     (8'h03)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr     (addr),
        .rdata    (rdata),
        .valid    (valid),
        .busy     (busy),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // ---------------- serial memory model ----------------
    int unsigned s_bits = 0;
    int unsigned s_k;
    logic [23:0] s_hdr  = '0;
    logic [15:0] s_a;
    logic [7:0]  s_b;

    always @(spi_sck or spi_cs_n) begin
        if (spi_cs_n !== 1'b0) begin
            s_bits   = 0;
            spi_miso = 1'b0;
        end else if (spi_sck === 1'b1) begin
            if (s_bits < 24) s_hdr = {s_hdr[22:0], spi_mosi};
            s_bits = s_bits + 1;
        end else if (s_bits >= 24) begin
            // after k data bits clocked out, present the next one
            s_k      = s_bits - 24;
            s_a      = s_hdr[15:0] + 16'(s_k / 8);
            s_b      = mem_byte(s_a);
            spi_miso = s_b[7 - (s_k % 8)];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch: wait gap idle cycles, request, wait for valid, check.
    // pre_idle = idle HOLD cycles already spent before this call.
    task automatic fetch(input logic [15:0] a, input int unsigned gap,
                         input int unsigned pre_idle, input bit noise,
                         input string tag);
        int unsigned idle, exp_lat, exp_cs, lat, cs_hi;
        bit          busy_bad, seen, full;
        logic [7:0]  exp_d;
        idle = gap + pre_idle;
        full = 1'b1;
        if (m_hold && idle < TO && m_last != 16'hFFFF && a == m_last + 16'd1) begin
            exp_lat = 16 * CD + 1; exp_cs = 0; full = 1'b0;
        end else if (m_hold && idle < TO) begin
            exp_lat = 64 * CD + 3; exp_cs = 2;
        end else begin
            exp_lat = 64 * CD + 1; exp_cs = 0;
        end
        exp_d = mem_byte(a);

        repeat (gap) tick();
        req = 1'b1; addr = a;
        tick();
        req = 1'b0; addr = 16'($urandom);
        lat = 1; cs_hi = 0; busy_bad = 1'b0; seen = 1'b0;
        while (lat < 400) begin
            if (valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (spi_cs_n === 1'b1) cs_hi++;
            if (noise && lat == 40) begin
                req = 1'b1; addr = ~a;
            end else begin
                req = 1'b0;
            end
            tick();
            lat++;
        end
        req = 1'b0;

        n_tests++;
        if (!seen || lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", tag, lat, seen, exp_lat);
        end
        n_tests++;
        if (rdata !== exp_d) begin
            n_fail++;
            $display("FAIL %s rdata addr=%h: got %h expected %h", tag, a, rdata, exp_d);
        end
        n_tests++;
        if (busy_bad || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy during transfer: low seen=%0d valid-cycle busy=%b expected 1", tag, busy_bad, busy);
        end
        n_tests++;
        if (cs_hi != exp_cs) begin
            n_fail++;
            $display("FAIL %s cs_n high cycles: got %0d expected %0d", tag, cs_hi, exp_cs);
        end
        if (full) begin
            n_tests++;
            if (s_hdr !== {8'h03, a}) begin
                n_fail++;
                $display("FAIL %s mosi header: got %h expected %h", tag, s_hdr, {8'h03, a});
            end
        end
        tick();
        n_tests++;
        if (valid !== 1'b0 || busy !== 1'b0 || spi_cs_n !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after valid: valid=%b busy=%b cs_n=%b expected 0 0 0", tag, valid, busy, spi_cs_n);
        end
        m_hold = 1'b1;
        m_last = a;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; addr = '0;
        #2;
        n_tests++;
        if ({spi_cs_n, spi_sck, spi_mosi, valid, busy, rdata} !== {5'b10000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset outputs: cs_n=%b sck=%b mosi=%b valid=%b busy=%b rdata=%h expected 1 0 0 0 0 00",
                     spi_cs_n, spi_sck, spi_mosi, valid, busy, rdata);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle after reset: cs_n=%b busy=%b expected 1 0", spi_cs_n, busy);
        end
        m_hold = 1'b0; m_last = '0;
    endtask

    task automatic test_idle_fetch();
        fetch(16'h0010, 0, 0, 1'b0, "idle_fetch");
    endtask

    task automatic test_sequential();
        fetch(16'h0011, 2, 0, 1'b0, "sequential");
    endtask

    task automatic test_nonsequential();
        fetch(16'h0100, 1, 0, 1'b0, "nonsequential");
    endtask

    task automatic test_wrap();
        fetch(16'hFFFF, 0, 0, 1'b0, "wrap_ffff");
        fetch(16'h0000, 0, 0, 1'b0, "wrap_0000");
    endtask

    task automatic test_timeout();
        bit bad;
        fetch(16'h0200, 0, 0, 1'b0, "timeout_setup");
        bad = 1'b0;
        for (int unsigned k = 0; k < TO; k++) begin
            if (spi_cs_n !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL timeout hold window: cs_n or busy left 0 before cycle %0d", TO);
        end
        n_tests++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout release: cs_n=%b busy=%b expected 1 0", spi_cs_n, busy);
        end
        m_hold = 1'b0;
        fetch(16'h0201, 0, 0, 1'b0, "after_timeout");
    endtask

    task automatic test_req_at_last_cycle();
        fetch(m_last + 16'd1, TO - 1, 0, 1'b0, "req_cycle63");
    endtask

    task automatic test_ignore_busy();
        bit bad;
        fetch(16'h0300, 0, 0, 1'b1, "ignore_busy");
        bad = 1'b0;
        repeat (3) begin
            if (busy !== 1'b0 || spi_cs_n !== 1'b0 || valid !== 1'b0) bad = 1'b1;
            tick();
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL ignored req was queued: busy/cs_n/valid moved, expected quiet HOLD");
        end
        fetch(16'h0301, 0, 3, 1'b0, "after_ignore");
    endtask

    task automatic test_random();
        logic [15:0]  a;
        int unsigned  g, r;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: a = m_last + 16'd1;
                1: a = 16'($urandom);
                2: a = 16'hFFFF;
                default: a = m_last + 16'($urandom_range(2, 5));
            endcase
            if ($urandom_range(0, 7) == 0) g = $urandom_range(TO - 2, TO + 2);
            else g = $urandom_range(0, 3);
            fetch(a, g, 0, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid();
        bit vseen;
        repeat (TO) tick();
        m_hold = 1'b0;
        n_tests++;
        if (spi_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL pre-reset idle: cs_n=%b expected 1", spi_cs_n);
        end
        req = 1'b1; addr = 16'h0420;
        tick();
        req = 1'b0;
        repeat (74) tick();      // high phase of address bit 10
        n_tests++;
        if (spi_sck !== 1'b1 || spi_cs_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid-address position: sck=%b cs_n=%b expected 1 0", spi_sck, spi_cs_n);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({spi_cs_n, spi_sck, spi_mosi, valid, busy, rdata} !== {5'b10000, 8'h00}) begin
            n_fail++;
            $display("FAIL async reset mid-transfer: cs_n=%b sck=%b mosi=%b valid=%b busy=%b rdata=%h expected 1 0 0 0 0 00",
                     spi_cs_n, spi_sck, spi_mosi, valid, busy, rdata);
        end
        vseen = 1'b0;
        repeat (3) begin
            tick();
            if (valid !== 1'b0) vseen = 1'b1;
        end
        rst = 1'b0;
        repeat (140) begin
            tick();
            if (valid !== 1'b0 || spi_cs_n !== 1'b1) vseen = 1'b1;
        end
        n_tests++;
        if (vseen) begin
            n_fail++;
            $display("FAIL aborted transfer resumed: valid pulse or cs_n low seen, expected none");
        end
        fetch(16'h0421, 0, 0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_idle_fetch();
        test_sequential();
        test_nonsequential();
        test_wrap();
        test_timeout();
        test_req_at_last_cycle();
        test_ignore_busy();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
